// File: rtl/tnn_sample_sequencer.sv
// Front-end sequencer for a combinational TNN classifier core: gathers a sample,
// holds it for an evaluation window, registers the class, and counts results.
//   state | meaning
//   LOAD  | accepting feature beats into core_in slots
//   EVAL  | core_in frozen, waiting out the evaluation window
//   DONE  | result presented on res_valid/res_class until accepted
module tnn_sample_sequencer #(
  parameter int N_FEAT      = 8,
  parameter int FEAT_W      = 2,
  parameter int EVAL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     feat_valid_i,
  output logic                     feat_ready_o,
  input  logic [FEAT_W-1:0]        feat_data_i,
  output logic [N_FEAT*FEAT_W-1:0] core_in_o,
  input  logic                     core_out_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     res_class_o,
  output logic [CNT_W-1:0]         sample_cnt_o,
  output logic [CNT_W-1:0]         pos_cnt_o
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int TMR_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic [N_FEAT*FEAT_W-1:0]   core_q, core_d;
  logic                       feat_ready_q, feat_ready_d;
  logic                       res_valid_q, res_valid_d;
  logic                       res_class_q, res_class_d;
  logic [CNT_W-1:0]           sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]           pos_cnt_q, pos_cnt_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    core_d       = core_q;
    res_valid_d  = res_valid_q;
    res_class_d  = res_class_q;
    sample_cnt_d = sample_cnt_q;
    pos_cnt_d    = pos_cnt_q;

    if (flush_i) begin
      state_d     = ST_LOAD;
      idx_d       = '0;
      tmr_d       = '0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (feat_valid_i && feat_ready_q) begin
            for (int k = 0; k < N_FEAT; k++) begin
              if (idx_q == IDX_W'(k)) core_d[k*FEAT_W +: FEAT_W] = feat_data_i;
            end
            if (idx_q == IDX_W'(N_FEAT-1)) begin
              state_d = ST_EVAL;
              idx_d   = '0;
              tmr_d   = TMR_W'(EVAL_CYCLES-1);
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_EVAL: begin
          if (tmr_q == '0) begin
            res_class_d = core_out_i;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            state_d     = ST_LOAD;
            res_valid_d = 1'b0;
            if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (res_class_q && (pos_cnt_q != '1)) pos_cnt_d = pos_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          res_valid_d = 1'b0;
        end
      endcase
    end

    // ready is a registered decode of the next state, so it never sees res_ready combinationally
    feat_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_LOAD;
      idx_q        <= '0;
      tmr_q        <= '0;
      core_q       <= '0;
      feat_ready_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_class_q  <= 1'b0;
      sample_cnt_q <= '0;
      pos_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      core_q       <= core_d;
      feat_ready_q <= feat_ready_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      sample_cnt_q <= sample_cnt_d;
      pos_cnt_q    <= pos_cnt_d;
    end
  end

  assign feat_ready_o = feat_ready_q;
  assign core_in_o    = core_q;
  assign res_valid_o  = res_valid_q;
  assign res_class_o  = res_class_q;
  assign sample_cnt_o = sample_cnt_q;
  assign pos_cnt_o    = pos_cnt_q;

endmodule
